// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, one-outstanding imem request channel, IF/ID register
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetched / perf_dropped counters)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pcf;
  logic [31:0] hold_data;
  logic [31:0] hold_pc;
  logic        accept;
  logic        deliver;
  logic        discard;
  logic [31:0] deliver_data;
  logic [31:0] deliver_pc;

  assign imem_req_valid = (state == REQ) && !StallF;
  assign imem_req_addr  = pcf;
  assign accept         = imem_req_valid && imem_req_ready;

  // A redirect always beats delivery: the returning word belongs to the old path.
  always_comb begin
    deliver      = 1'b0;
    discard      = 1'b0;
    deliver_data = imem_rsp_data;
    deliver_pc   = pcf;
    case (state)
      WAIT: begin
        if (imem_rsp_valid) begin
          if (PCSrcE)       discard = 1'b1;
          else if (!StallD) deliver = 1'b1;
        end
      end
      HOLD: begin
        deliver_data = hold_data;
        deliver_pc   = hold_pc;
        if (PCSrcE)       discard = 1'b1;
        else if (!StallD) deliver = 1'b1;
      end
      DROP:    discard = imem_rsp_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= REQ;
      pcf       <= RESET_PC;
      hold_data <= 32'h0;
      hold_pc   <= 32'h0;
    end else begin
      case (state)
        REQ: begin
          if (PCSrcE) begin
            pcf <= PCTargetE;
            if (accept) state <= DROP;
          end else if (accept) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (PCSrcE) begin
            pcf   <= PCTargetE;
            state <= imem_rsp_valid ? REQ : DROP;
          end else if (imem_rsp_valid) begin
            if (StallD) begin
              hold_data <= imem_rsp_data;
              hold_pc   <= pcf;
              state     <= HOLD;
            end else begin
              pcf   <= pcf + 32'd4;
              state <= REQ;
            end
          end
        end
        HOLD: begin
          if (PCSrcE) begin
            pcf   <= PCTargetE;
            state <= REQ;
          end else if (!StallD) begin
            pcf   <= pcf + 32'd4;
            state <= REQ;
          end
        end
        DROP: begin
          if (PCSrcE)         pcf   <= PCTargetE;
          if (imem_rsp_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  // Flush keeps PCD/PCPlus4D; only the instruction and valid bit are bubbled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      InstrD   <= NOP;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (StallD) begin
      ValidD <= ValidD;
    end else if (deliver) begin
      InstrD   <= deliver_data;
      PCD      <= deliver_pc;
      PCPlus4D <= deliver_pc + 32'd4;
      ValidD   <= 1'b1;
    end else begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetched <= 32'h0;
      perf_dropped <= 32'h0;
    end else begin
      if (deliver) perf_fetched <= perf_fetched + 32'd1;
      if (discard) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a behavioural instruction memory
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .resetn(resetn), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   compared = 0;
  int   mismatched = 0;
  int   exp_fetched = 0;
  int   exp_dropped = 0;
  int   mem_delay = 1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pcd = 32'h0;
  logic [31:0] saved;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    exp_q.push_back('{instr_of(pc), pc, pc4});
    exp_fetched++;
  endtask

  // Instruction memory: samples acceptance mid-cycle, answers mem_delay cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && imem_req_valid && imem_req_ready) begin
        pend = 1'b1; pend_addr = imem_req_addr; pend_cnt = mem_delay;
      end
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      if (!resetn) pend = 1'b0;
      else if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rsp_valid = 1'b1; imem_rsp_data = instr_of(pend_addr); pend = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every fresh IF/ID delivery pops one expected entry.
  always @(negedge clk) begin
    if (resetn && ValidD && (!prev_valid || PCD != prev_pcd)) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL delivery_unexpected: got pc=%h instr=%h, required no delivery", PCD, InstrD);
      end else begin
        e = exp_q.pop_front();
        if (InstrD !== e.instr || PCD !== e.pc || PCPlus4D !== e.pc4) begin
          mismatched++;
          $display("FAIL delivery: got instr=%h pc=%h pc4=%h, required instr=%h pc=%h pc4=%h",
                   InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pc4);
        end
      end
    end
    prev_valid = ValidD;
    prev_pcd   = PCD;
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #2; n++; end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: got %0d deliveries pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; imem_req_ready = 1'b0; exp_fetched = 0; exp_dropped = 0;
    repeat (2) @(posedge clk); #1;
    compared++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC}) begin
      mismatched++; $display("FAIL reset_req: got %b/%h, required 1/%h", imem_req_valid, imem_req_addr, RST_PC);
    end
    compared++;
    if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b0, NOP, 32'h0, 32'h0}) begin
      mismatched++; $display("FAIL reset_ifid: got v=%b i=%h pc=%h pc4=%h, required 0/%h/0/0", ValidD, InstrD, PCD, PCPlus4D, NOP);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] a;
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    @(posedge clk); #1; resetn = 1'b1; imem_req_ready = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      compared++;
      if (ValidD !== (i > 0 && i % 2 == 0)) begin
        mismatched++; $display("FAIL seq_validd[%0d]: got %b, required %b", i, ValidD, (i > 0 && i % 2 == 0));
      end
      compared++;
      if (imem_req_valid !== (i % 2 == 0)) begin
        mismatched++; $display("FAIL seq_reqvalid[%0d]: got %b, required %b", i, imem_req_valid, (i % 2 == 0));
      end
      if (i % 2 == 0) begin
        a = 32'h100 + 32'(2 * i);
        compared++;
        if (imem_req_addr !== a) begin
          mismatched++; $display("FAIL seq_addr[%0d]: got %h, required %h", i, imem_req_addr, a);
        end
      end
      if (i == 5) imem_req_ready = 1'b0;
    end
    wait_drain("seq");
  endtask

  task automatic test_stall_hold;
    @(posedge clk); #1; imem_req_ready = 1'b1;
    @(posedge clk); #1; imem_req_ready = 1'b0; StallD = 1'b1; saved = InstrD;
    push_exp(32'h10C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if ({imem_req_valid, ValidD, InstrD} !== {1'b0, 1'b0, saved}) begin
        mismatched++; $display("FAIL hold_stall[%0d]: got req=%b v=%b i=%h, required 0/0/%h", i, imem_req_valid, ValidD, InstrD, saved);
      end
      @(posedge clk); #1;
    end
    StallD = 1'b0;
    wait_drain("hold");
    @(negedge clk);
    compared++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h110}) begin
      mismatched++; $display("FAIL hold_next: got %b/%h, required 1/00000110", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_drop;
    mem_delay = 3;
    @(posedge clk); #1; imem_req_ready = 1'b1;
    @(posedge clk); #1; imem_req_ready = 1'b0; PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h200;
    @(posedge clk); #1; PCSrcE = 1'b0; FlushD = 1'b0; exp_dropped++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if ({imem_req_valid, ValidD} !== 2'b00) begin
        mismatched++; $display("FAIL drop_wait[%0d]: got req=%b v=%b, required 0/0", i, imem_req_valid, ValidD);
      end
      if (i == 0) begin @(posedge clk); #1; end
    end
    mem_delay = 1; imem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    if ({imem_req_valid, imem_req_addr, ValidD} !== {1'b1, 32'h200, 1'b0}) begin
      mismatched++; $display("FAIL drop_next: got %b/%h v=%b, required 1/00000200 v=0", imem_req_valid, imem_req_addr, ValidD);
    end
    push_exp(32'h200);
    @(posedge clk); #1; imem_req_ready = 1'b0;
    wait_drain("drop");
  endtask

  task automatic test_redirect_with_rsp;
    @(posedge clk); #1; imem_req_ready = 1'b1;
    @(posedge clk); #1; imem_req_ready = 1'b0; PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h200;
    @(posedge clk); #1; PCSrcE = 1'b0; FlushD = 1'b0; exp_dropped++;
    @(negedge clk);
    compared++;
    if ({InstrD, ValidD} !== {NOP, 1'b0}) begin
      mismatched++; $display("FAIL rsp_flush: got i=%h v=%b, required %h/0", InstrD, ValidD, NOP);
    end
    compared++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h200}) begin
      mismatched++; $display("FAIL rsp_next: got %b/%h, required 1/00000200", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stallf;
    @(posedge clk); #1; StallF = 1'b1; imem_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if ({imem_req_valid, imem_req_addr} !== {1'b0, 32'h200}) begin
        mismatched++; $display("FAIL stallf[%0d]: got %b/%h, required 0/00000200", i, imem_req_valid, imem_req_addr);
      end
      @(posedge clk); #1;
    end
    StallF = 1'b0;
    @(negedge clk);
    compared++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h200}) begin
      mismatched++; $display("FAIL stallf_resume: got %b/%h, required 1/00000200", imem_req_valid, imem_req_addr);
    end
    push_exp(32'h200);
    @(posedge clk); #1; imem_req_ready = 1'b0;
    wait_drain("stallf");
  endtask

  task automatic test_wrap;
    @(posedge clk); #1; PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    @(posedge clk); #1; PCSrcE = 1'b0; FlushD = 1'b0;
    push_exp(32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    @(posedge clk); #1; imem_req_ready = 1'b0;
    wait_drain("wrap");
    @(negedge clk);
    compared++;
    if ({PCPlus4D, imem_req_addr} !== {32'h0, 32'h0}) begin
      mismatched++; $display("FAIL wrap: got pc4=%h addr=%h, required 0/0", PCPlus4D, imem_req_addr);
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1; PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h40;
    @(posedge clk); #1; PCSrcE = 1'b0; FlushD = 1'b0; imem_req_ready = 1'b1; push_exp(32'h40);
    @(posedge clk); #1; imem_req_ready = 1'b0;
    @(posedge clk); #1; StallD = 1'b1; imem_req_ready = 1'b1; mem_delay = 4;
    @(posedge clk); #1; imem_req_ready = 1'b0;
    compared++;
    if ({ValidD, PCD, imem_req_valid} !== {1'b1, 32'h40, 1'b0}) begin
      mismatched++; $display("FAIL async_pre: got v=%b pc=%h req=%b, required 1/00000040/0", ValidD, PCD, imem_req_valid);
    end
`ifdef FETCH_PERF_CNT_EN
    compared++;
    if ({perf_fetched, perf_dropped} !== {32'(exp_fetched), 32'(exp_dropped)}) begin
      mismatched++; $display("FAIL perf_counts: got %0d/%0d, required %0d/%0d", perf_fetched, perf_dropped, exp_fetched, exp_dropped);
    end
`endif
    #2; resetn = 1'b0;
    #1;
    compared++;
    if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b0, NOP, 32'h0, 32'h0}) begin
      mismatched++; $display("FAIL async_ifid: got v=%b i=%h pc=%h pc4=%h, required 0/%h/0/0", ValidD, InstrD, PCD, PCPlus4D, NOP);
    end
    compared++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC}) begin
      mismatched++; $display("FAIL async_req: got %b/%h, required 1/%h", imem_req_valid, imem_req_addr, RST_PC);
    end
`ifdef FETCH_PERF_CNT_EN
    compared++;
    if ({perf_fetched, perf_dropped} !== 64'h0) begin
      mismatched++; $display("FAIL perf_reset: got %0d/%0d, required 0/0", perf_fetched, perf_dropped);
    end
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    StallD = 1'b0; mem_delay = 1; imem_req_ready = 1'b1; resetn = 1'b1;
    exp_fetched = 0; exp_dropped = 0;
    push_exp(RST_PC);
    @(negedge clk);
    compared++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC}) begin
      mismatched++; $display("FAIL async_first: got %b/%h, required 1/%h", imem_req_valid, imem_req_addr, RST_PC);
    end
    @(posedge clk); #1; imem_req_ready = 1'b0;
    wait_drain("async");
  endtask

  initial begin
    resetn = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0; imem_req_ready = 1'b0;
    test_reset;
    test_sequential;
    test_stall_hold;
    test_redirect_drop;
    test_redirect_with_rsp;
    test_stallf;
    test_wrap;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
